// File: rtl/block_sequencer_pkg.sv
// Shared types and helpers for the block sequencer: FSM states, table width and
// the mirror-counter arithmetic used to find the last pair of a block.
package jpeg_pkg;

    localparam int TBL_W = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [6:0] pos_sum(input logic [6:0] pos, input logic [3:0] run);
        return pos + {3'b000, run} + 7'd1;
    endfunction

    // A pair closes its block when it lands on (or overruns) position 63, or is an EOB.
    function automatic logic last_of_block(input logic [6:0] pos, input logic [3:0] run,
                                           input logic [7:0] coeff);
        logic [6:0] sum;
        sum = pos_sum(pos, run);
        return (sum >= 7'd64) || ((pos != 7'd0) && (run == 4'd0) && (coeff == 8'd0));
    endfunction

endpackage

// File: rtl/block_sequencer_if.sv
// Bundle of every non-clock signal of the block sequencer: entropy-decoder input,
// table-generator control/observation, IDCT output and status.
interface block_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int TBL_W = jpeg_pkg::TBL_W
);
    // Handshakes (in_*, out_*): a transfer happens on a rising clk edge where valid and
    // ready are both high; valid never waits for ready, and payload is held while
    // valid is high and ready is low.
    logic                 start;
    logic [CNT_W-1:0]     cfg_num_blocks;
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           in_run;
    logic [7:0]           in_coeff;
    logic                 tg_clear;
    logic                 tg_new;
    logic [3:0]           tg_run;
    logic [7:0]           tg_coeff;
    logic                 tg_valid;
    logic [TBL_W-1:0]     tg_table;
    logic                 out_valid;
    logic                 out_ready;
    logic [TBL_W-1:0]     out_table;
    logic [CNT_W-1:0]     out_index;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic                 sync_err;
    jpeg_pkg::state_t     dbg_state;

    modport master (
        input  start, cfg_num_blocks, in_valid, in_run, in_coeff, tg_valid, tg_table, out_ready,
        output in_ready, tg_clear, tg_new, tg_run, tg_coeff, out_valid, out_table, out_index,
               out_last, busy, done, sync_err, dbg_state
    );

    modport slave (
        output start, cfg_num_blocks, in_valid, in_run, in_coeff, tg_valid, tg_table, out_ready,
        input  in_ready, tg_clear, tg_new, tg_run, tg_coeff, out_valid, out_table, out_index,
               out_last, busy, done, sync_err, dbg_state
    );

endinterface

// File: rtl/block_buffer.sv
// Two-entry FIFO holding completed blocks ({last, index, table}); push and pop may
// happen in the same cycle, and a push into a full buffer is only taken with a pop.
module block_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/block_sequencer.sv
// Sequences one image of run/coefficient pairs into the table generator, mirrors its
// block position, buffers finished tables and hands them to the IDCT.
module block_sequencer #(
    parameter int CNT_W = 16,
    parameter int TBL_W = jpeg_pkg::TBL_W
) (
    input logic clk,
    input logic rst,
    block_sequencer_if.master bus
);
    import jpeg_pkg::*;

    localparam int BUF_W = TBL_W + CNT_W + 1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_in_blk;
    logic [CNT_W-1:0] r_idx;
    logic [6:0]       r_pos;
    logic [1:0]       r_resv;
    logic             r_pend;
    logic             r_sync_err;

    logic             w_in_ready;
    logic             w_accept;
    logic [6:0]       w_sum;
    logic             w_lob;
    logic             w_last_accept;
    logic             w_final_blk;
    logic             w_start_ok;
    logic             w_pop;
    logic             w_drain_ok;
    logic             w_buf_valid;
    logic [1:0]       w_buf_count;
    logic [BUF_W-1:0] w_push_data;
    logic [BUF_W-1:0] w_head;
    logic [TBL_W-1:0] w_cap_table;
    logic             w_cap_last;

    // A new block may only start while a buffer slot is still unreserved.
    assign w_in_ready    = (r_state == ST_RUN) & ((r_pos != 7'd0) | (r_resv < 2'd2));
    assign w_accept      = bus.in_valid & w_in_ready;
    assign w_sum         = pos_sum(r_pos, bus.in_run);
    assign w_lob         = last_of_block(r_pos, bus.in_run, bus.in_coeff);
    assign w_last_accept = w_accept & w_lob;
    assign w_final_blk   = (r_in_blk == (r_num - ONE));
    assign w_start_ok    = bus.start & (r_state == ST_IDLE);
    assign w_pop         = w_buf_valid & bus.out_ready;
    assign w_drain_ok    = ~r_pend & ((w_buf_count == 2'd0) | ((w_buf_count == 2'd1) & w_pop));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = (bus.cfg_num_blocks == '0) ? ST_DONE : ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last_accept && w_final_blk) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_ok) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_num      <= '0;
            r_in_blk   <= '0;
            r_idx      <= '0;
            r_pos      <= 7'd0;
            r_resv     <= 2'd0;
            r_pend     <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_last_accept;
            if (w_start_ok) begin
                r_num      <= bus.cfg_num_blocks;
                r_in_blk   <= '0;
                r_idx      <= '0;
                r_pos      <= 7'd0;
                r_sync_err <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_pos <= w_lob ? 7'd0 : w_sum;
                end
                if (w_last_accept) begin
                    r_in_blk <= r_in_blk + ONE;
                end
                if (r_pend) begin
                    r_idx <= r_idx + ONE;
                end
                if ((w_accept && (w_sum > 7'd64)) || (bus.tg_valid != r_pend)) begin
                    r_sync_err <= 1'b1;
                end
            end
            case ({w_accept & (r_pos == 7'd0), w_pop})
                2'b10:   r_resv <= r_resv + 2'd1;
                2'b01:   r_resv <= r_resv - 2'd1;
                default: r_resv <= r_resv;
            endcase
        end
    end

    // A missing generator strobe still produces a (zero) block so indices stay aligned.
    assign w_cap_table = bus.tg_valid ? bus.tg_table : '0;
    assign w_cap_last  = (r_idx == (r_num - ONE));
    assign w_push_data = {w_cap_last, r_idx, w_cap_table};

    block_buffer #(.DATA_W(BUF_W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_pend),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_valid (w_buf_valid),
        .o_data  (w_head),
        .o_count (w_buf_count)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.tg_clear  = rst | (r_state == ST_CLEAR);
    assign bus.tg_new    = w_accept;
    assign bus.tg_run    = bus.in_run;
    assign bus.tg_coeff  = bus.in_coeff;
    assign bus.out_valid = w_buf_valid;
    assign bus.out_table = w_head[TBL_W-1:0];
    assign bus.out_index = w_head[TBL_W +: CNT_W];
    assign bus.out_last  = w_head[BUF_W-1];
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.sync_err  = r_sync_err;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_block_sequencer.sv
// Directed bench for block_sequencer with a behavioural table-generator model and a
// scoreboard of expected {last, index, table} entries.
module tb_block_sequencer;

    localparam int CNT_W = 16;
    localparam int TBL_W = 1024;
    localparam int EXP_W = TBL_W + CNT_W + 1;

    logic clk;
    logic rst;

    block_sequencer_if #(.CNT_W(CNT_W), .TBL_W(TBL_W)) bus ();

    block_sequencer #(.CNT_W(CNT_W), .TBL_W(TBL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [11:0]      pairs_q[$];
    logic [6:0]       m_pos = 7'd0;
    int               exp_idx = 0;
    int               exp_n = 0;
    int               acc_cnt = 0;
    int               lob_cyc = 0;
    int               last_hs_cyc = 0;
    int               done_cyc = 0;
    int               first_acc_cyc = -1;
    int               last_acc_cyc = 0;
    bit               done_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_tbl(input string tag, input logic [TBL_W-1:0] obs,
                             input logic [TBL_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic drive_in();
        if (pairs_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_run   = pairs_q[0][11:8];
            bus.in_coeff = pairs_q[0][7:0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_run   = 4'd0;
            bus.in_coeff = 8'd0;
        end
    endtask

    task automatic add_pair(input logic [3:0] r, input logic [7:0] c);
        pairs_q.push_back({r, c});
        drive_in();
    endtask

    // One clock: observe the current cycle, advance, then drive the next cycle.
    task automatic tick();
        logic             acc;
        logic             fire;
        logic             lst;
        logic [TBL_W-1:0] tbl;
        logic [EXP_W-1:0] e;
        #1;
        acc  = bus.in_valid & bus.in_ready;
        fire = 1'b0;
        check("tg_new", bus.tg_new, acc);
        if (bus.in_valid) begin
            check("tg_run", bus.tg_run, bus.in_run);
            check("tg_coeff", bus.tg_coeff, bus.in_coeff);
        end
        if (bus.tg_clear) begin
            m_pos = 7'd0;
        end else if (acc) begin
            acc_cnt++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            if (jpeg_pkg::last_of_block(m_pos, bus.in_run, bus.in_coeff)) begin
                fire    = 1'b1;
                m_pos   = 7'd0;
                lob_cyc = cyc;
            end else begin
                m_pos = jpeg_pkg::pos_sum(m_pos, bus.in_run);
            end
        end
        if (bus.out_valid && bus.out_ready) begin
            last_hs_cyc = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=block index %0d expected=no block", bus.out_index);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_tbl("sb_table", bus.out_table, e[TBL_W-1:0]);
                check("sb_index", bus.out_index, e[TBL_W +: CNT_W]);
                check("sb_last", bus.out_last, e[EXP_W-1]);
            end
        end
        if (bus.done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) pairs_q.delete(0);
        drive_in();
        bus.tg_valid = fire;
        tbl = '0;
        if (fire) begin
            for (int k = 0; k < TBL_W / 32; k++) tbl[k*32 +: 32] = $urandom();
            lst = (exp_idx == exp_n - 1);
            e   = {lst, CNT_W'(exp_idx), tbl};
            exp_q.push_back(e);
            exp_idx++;
        end
        bus.tg_table = tbl;
    endtask

    task automatic start_image(input int n);
        exp_n              = n;
        exp_idx            = 0;
        bus.cfg_num_blocks = CNT_W'(n);
        bus.start          = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        done_seen = 1'b0;
        for (int i = 0; i < budget && !done_seen; i++) tick();
        check({tag, "_done_seen"}, done_seen, 1'b1);
        if (done_seen) begin
            check({tag, "_done_after_hs"}, done_cyc - last_hs_cyc, 1);
            check({tag, "_done_width"}, bus.done, 1'b0);
        end
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.cfg_num_blocks = '0;
        bus.in_valid       = 1'b0;
        bus.in_run         = 4'd0;
        bus.in_coeff       = 8'd0;
        bus.tg_valid       = 1'b0;
        bus.tg_table       = '0;
        bus.out_ready      = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_tg_clear", bus.tg_clear, 1'b1);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sync_err", bus.sync_err, 1'b0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 1'b0);
        check_tbl("rst_out_table", bus.out_table, '0);
        rst = 1'b0;
        tick();
        check("idle_tg_clear", bus.tg_clear, 1'b0);
        check("idle_state", bus.dbg_state, jpeg_pkg::ST_IDLE);

        // N=1: DC then EOB
        bus.out_ready = 1'b0;
        start_image(1);
        check("t1_clear_state", bus.dbg_state, jpeg_pkg::ST_CLEAR);
        check("t1_clear_pulse", bus.tg_clear, 1'b1);
        check("t1_busy", bus.busy, 1'b1);
        check("t1_in_ready_clear", bus.in_ready, 1'b0);
        add_pair(4'd0, 8'd5);
        add_pair(4'd0, 8'd0);
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        check("t1_out_valid", bus.out_valid, 1'b1);
        check("t1_latency", cyc - lob_cyc, 2);
        check("t1_index", bus.out_index, 0);
        check("t1_last", bus.out_last, 1'b1);
        bus.out_ready = 1'b1;
        wait_done("t1", 20);
        check("t1_sync_err", bus.sync_err, 1'b0);

        // N=2: full 64-pair block without EOB, then a short block; one pair per cycle
        acc_cnt       = 0;
        first_acc_cyc = -1;
        start_image(2);
        for (int i = 0; i < 64; i++) add_pair(4'd0, 8'($urandom_range(1, 255)));
        add_pair(4'd0, 8'd7);
        add_pair(4'd0, 8'd0);
        wait_done("t2", 200);
        check("t2_acc_cnt", acc_cnt, 66);
        check("t2_throughput", last_acc_cyc - first_acc_cyc, 65);
        check("t2_sync_err", bus.sync_err, 1'b0);

        // N=4 with out_ready low: two blocks fit, the third block stalls at its first pair
        bus.out_ready = 1'b0;
        acc_cnt       = 0;
        start_image(4);
        for (int b = 0; b < 4; b++) begin
            add_pair(4'd0, 8'd1);
            add_pair(4'd2, 8'd3);
            add_pair(4'd0, 8'd0);
        end
        for (int i = 0; i < 30; i++) tick();
        check("t3_acc_stall", acc_cnt, 6);
        check("t3_in_ready_low", bus.in_ready, 1'b0);
        check("t3_captured", exp_q.size(), 2);
        check("t3_out_valid", bus.out_valid, 1'b1);
        check("t3_head_index", bus.out_index, 0);
        bus.out_ready = 1'b1;
        wait_done("t3", 100);
        check("t3_acc_total", acc_cnt, 12);
        check("t3_pairs_left", pairs_q.size(), 0);

        // Overrun: run 15 at position 60
        start_image(2);
        for (int i = 0; i < 60; i++) add_pair(4'd0, 8'($urandom_range(1, 255)));
        add_pair(4'd15, 8'd9);
        add_pair(4'd0, 8'd3);
        add_pair(4'd0, 8'd0);
        wait_done("t4", 200);
        check("t4_sync_err", bus.sync_err, 1'b1);

        // N=0: straight to DONE, and the accepted start clears sync_err
        start_image(0);
        check("t5_done", bus.done, 1'b1);
        check("t5_sync_err_clr", bus.sync_err, 1'b0);
        check("t5_in_ready", bus.in_ready, 1'b0);
        tick();
        check("t5_done_width", bus.done, 1'b0);
        check("t5_busy", bus.busy, 1'b0);

        // start while running is ignored; N stays 2
        acc_cnt = 0;
        start_image(2);
        tick();
        tick();
        check("t6_running", bus.dbg_state, jpeg_pkg::ST_RUN);
        bus.cfg_num_blocks = CNT_W'(1);
        bus.start          = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t6_still_run", bus.dbg_state, jpeg_pkg::ST_RUN);
        add_pair(4'd0, 8'd1);
        add_pair(4'd0, 8'd0);
        add_pair(4'd0, 8'd2);
        add_pair(4'd0, 8'd0);
        wait_done("t6", 50);
        check("t6_acc_cnt", acc_cnt, 4);

        // Asynchronous reset mid-image, then a clean N=1 image
        bus.out_ready = 1'b0;
        start_image(2);
        add_pair(4'd0, 8'd1);
        add_pair(4'd0, 8'd0);
        add_pair(4'd0, 8'd4);
        add_pair(4'd1, 8'd5);
        for (int i = 0; i < 8; i++) tick();
        check("t7_buffered", bus.out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_out_valid", bus.out_valid, 1'b0);
        check("t7_rst_in_ready", bus.in_ready, 1'b0);
        check("t7_rst_busy", bus.busy, 1'b0);
        check("t7_rst_tg_clear", bus.tg_clear, 1'b1);
        check("t7_rst_tg_new", bus.tg_new, 1'b0);
        check("t7_rst_out_index", bus.out_index, 0);
        check("t7_rst_out_last", bus.out_last, 1'b0);
        check_tbl("t7_rst_out_table", bus.out_table, '0);
        exp_q.delete();
        pairs_q.delete();
        drive_in();
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        start_image(1);
        add_pair(4'd0, 8'd5);
        add_pair(4'd0, 8'd0);
        wait_done("t7", 30);
        check("t7_sync_err", bus.sync_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
